// File: rtl/tour_pkg.sv
// Shared definitions for the tour command sequencer: Knight command encodings,
// sequencer state and error code types, and a move-command builder.
package tour_pkg;

  // Command opcodes (top nibble of a 16-bit Knight command).
  localparam logic [3:0] CAL      = 4'h2;
  localparam logic [3:0] MOVE     = 4'h4;
  localparam logic [3:0] MOVE_FAN = 4'h5;

  // Headings (middle byte of a move command).
  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitSent,
    StWaitResp,
    StDone,
    StErr
  } seq_state_t;

  typedef enum logic [1:0] {
    ErrNone    = 2'b00,
    ErrBadResp = 2'b01,
    ErrTimeout = 2'b10
  } err_code_t;

  // Build a move command: {opcode, heading, squares}.
  function automatic logic [15:0] mk_move(input logic       fanfare,
                                          input logic [7:0] heading,
                                          input logic [3:0] squares);
    return {(fanfare ? MOVE_FAN : MOVE), heading, squares};
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Saturating 24-bit wait-cycle counter. expire flags the enabled cycle whose
// increment brings the count to LIMIT, so the owner can react on that edge.
module seq_timeout_cnt #(
  parameter logic [23:0] LIMIT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [23:0] cnt_q;

  // Count enabled cycles since the last clear, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

  // Widened compare so the saturated value cannot wrap back below LIMIT.
  always_comb begin
    expire = enable && !clear && (({1'b0, cnt_q} + 25'd1) >= {1'b0, LIMIT});
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a programmed list of Knight commands to RemoteComm, one at a time,
// waiting for cmd_sent/resp_rdy, checking the response byte and enforcing a
// per-command timeout.
module tour_cmd_sequencer
  import tour_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000,
  parameter logic [7:0]  ACK     = 8'hA5,
  localparam int unsigned IW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_we,
  input  logic [IW-1:0] ld_addr,
  input  logic [15:0]   ld_data,
  input  logic [IW:0]   num_cmds,
  input  logic          start,
  output logic [15:0]   cmd,
  output logic          send_cmd,
  input  logic          cmd_sent,
  input  logic          resp_rdy,
  input  logic [7:0]    resp,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [IW-1:0] cmd_idx
);

  localparam logic [IW:0] NumOne = 1;

  seq_state_t    state_q;
  logic [15:0]   prog_q [DEPTH];
  logic [15:0]   cmd_q;
  logic          send_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  err_code_t     err_code_q;
  logic [IW-1:0] idx_q;

  logic tmo_clear;
  logic tmo_en;
  logic tmo_expire;
  logic resp_take;
  logic last_cmd;

  // Timer qualifiers and response acceptance (resp_rdy with cmd_sent counts in WAIT_SENT).
  always_comb begin
    tmo_clear = (state_q == StSend);
    tmo_en    = (state_q == StWaitSent) || (state_q == StWaitResp);
    resp_take = resp_rdy &&
                ((state_q == StWaitResp) || ((state_q == StWaitSent) && cmd_sent));
    last_cmd  = ({1'b0, idx_q} == (num_cmds - NumOne));
  end

  seq_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expire (tmo_expire)
  );

  // Program buffer load port; locked while a sequence runs.
  always_ff @(posedge clk) begin
    if (ld_we && !busy_q) begin
      prog_q[ld_addr] <= ld_data;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
      idx_q      <= '0;
    end else begin
      send_q <= 1'b0;
      unique case (state_q)
        // DONE and ERR hold their flags but accept start exactly like IDLE.
        StIdle, StDone, StErr: begin
          if (start) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            idx_q      <= '0;
            if (num_cmds == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StLoad;
              busy_q  <= 1'b1;
            end
          end
        end
        StLoad: begin
          cmd_q   <= prog_q[idx_q];
          send_q  <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          state_q <= StWaitSent;
        end
        StWaitSent, StWaitResp: begin
          // A response on the expiry cycle still counts.
          if (resp_take) begin
            if (resp != ACK) begin
              state_q    <= StErr;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ErrBadResp;
            end else if (last_cmd) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= StLoad;
            end
          end else if (tmo_expire) begin
            state_q    <= StErr;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ErrTimeout;
          end else if ((state_q == StWaitSent) && cmd_sent) begin
            state_q <= StWaitResp;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cmd      = cmd_q;
    send_cmd = send_q;
    busy     = busy_q;
    done     = done_q;
    err      = err_q;
    err_code = err_code_q;
    cmd_idx  = idx_q;
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: a schedule-level model predicts every output per
// cycle from the sequencing rules; directed runs pin the model with literals.
module tb_tour_cmd_sequencer;
  import tour_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int          TO    = 1000;
  localparam logic [7:0]  ACKB  = 8'hA5;
  localparam int          NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_we = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [4:0]  num_cmds = '0;
  logic        start = 1'b0;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [3:0]  cmd_idx;

  tour_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (24'(TO)),
    .ACK     (ACKB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .num_cmds (num_cmds),
    .start    (start),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .cmd_idx  (cmd_idx)
  );

  always #5 clk = ~clk;

  // Model state: buffer image, per-command responder plan, expected outputs.
  logic [15:0] mem [DEPTH];
  int          a_del [DEPTH];
  int          b_del [DEPTH];
  bit          ack_ok [DEPTH];
  bit          spur [DEPTH];
  logic [7:0]  bad_val [DEPTH];

  logic [15:0] exp_cmd = '0;
  bit          exp_send = 0, exp_busy = 0, exp_done = 0, exp_err = 0;
  logic [1:0]  exp_code = '0;
  logic [3:0]  exp_idx = '0;
  bit          chk_en = 0;

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [15:0] sent_q[$];
  int          send_cyc_q[$];
  int          err_cyc = -1, start_cyc = 0;
  bit          err_prev = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic logic [15:0] sent_at(input int i);
    return (sent_q.size() > i) ? sent_q[i] : 16'hFFFF;
  endfunction

  function automatic int send_cyc_at(input int i);
    return (send_cyc_q.size() > i) ? send_cyc_q[i] : -1000;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("send_cmd", 16'(send_cmd), 16'(exp_send));
      check("cmd", cmd, exp_cmd);
      check("busy", 16'(busy), 16'(exp_busy));
      check("done", 16'(done), 16'(exp_done));
      check("err", 16'(err), 16'(exp_err));
      check("err_code", 16'(err_code), 16'(exp_code));
      check("cmd_idx", 16'(cmd_idx), 16'(exp_idx));
    end
    if (send_cmd) begin
      sent_q.push_back(cmd);
      send_cyc_q.push_back(cyc);
    end
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [15:0] data);
    ld_we   = 1'b1;
    ld_addr = 4'(addr);
    ld_data = data;
    if (!exp_busy) mem[addr] = data;
    tick();
    ld_we = 1'b0;
  endtask

  // One sequence: the schedule is derived first (send cycles, accept cycles,
  // final outcome), then the loop drives the responder and expected outputs.
  task automatic run(input int n, input int wr_at, input int abort_at, input bit rand_start);
    int s [DEPTH];
    int acc, last_k, end_t, stop_t, fin_idx;
    bit fin_done;
    logic [1:0] fin_code;
    last_k = 0; end_t = 0; fin_done = 0; fin_code = 2'b00; fin_idx = 0;
    if (n > 0) begin
      s[0] = 2;
      for (int k = 0; k < n; k++) begin
        last_k = k;
        if (b_del[k] <= TO) begin
          acc = s[k] + b_del[k];
          if (!ack_ok[k]) begin
            end_t = acc; fin_code = 2'b01; fin_idx = k; break;
          end
          if (k == n - 1) begin
            end_t = acc; fin_done = 1; fin_idx = k; break;
          end
          s[k+1] = acc + 2;
        end else begin
          end_t = s[k] + TO; fin_code = 2'b10; fin_idx = k; break;
        end
      end
    end
    stop_t = (abort_at >= 0) ? abort_at + 6 : ((n > 0) ? end_t + 3 : 3);
    sent_q.delete();
    send_cyc_q.delete();
    err_cyc   = -1;
    num_cmds  = 5'(n);
    start     = 1'b1;
    start_cyc = cyc;
    for (int t = 1; t <= stop_t; t++) begin
      tick();
      start = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0; resp = 8'h00; ld_we = 1'b0;
      if (abort_at >= 0 && t >= abort_at) begin
        rst_n    = (t >= abort_at + 3);
        exp_cmd  = '0; exp_send = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
        exp_code = '0; exp_idx = '0;
        continue;
      end
      if (t == 1) begin
        exp_done = (n == 0); exp_err = 0; exp_code = 2'b00; exp_idx = '0; exp_busy = (n > 0);
      end
      exp_send = 0;
      if (n > 0) begin
        for (int k = 0; k <= last_k; k++) begin
          if (t == s[k]) begin
            exp_send = 1;
            exp_cmd  = mem[k];
            if (spur[k]) begin resp_rdy = 1'b1; resp = ACKB; end
          end
          if (t == s[k] + a_del[k]) cmd_sent = 1'b1;
          if (t == s[k] + b_del[k]) begin
            resp_rdy = 1'b1;
            resp     = ack_ok[k] ? ACKB : bad_val[k];
          end
          if (k < last_k && t == s[k+1] - 1) exp_idx = 4'(k + 1);
        end
        if (t == end_t + 1) begin
          exp_busy = 0; exp_done = fin_done; exp_err = !fin_done;
          exp_code = fin_code; exp_idx = 4'(fin_idx);
        end
        // Responder chatter once finished must be ignored.
        if (t == end_t + 2) begin resp_rdy = 1'b1; cmd_sent = 1'b1; resp = ACKB; end
        if (rand_start && t <= end_t && $urandom_range(0, 99) < 3) start = 1'b1;
      end
      if (t == wr_at) begin
        ld_we = 1'b1; ld_addr = 4'd0; ld_data = 16'hDEAD;
        if (!exp_busy) mem[0] = 16'hDEAD;
      end
    end
  endtask

  task automatic plan_default(input int a, input int b);
    for (int k = 0; k < DEPTH; k++) begin
      a_del[k] = a; b_del[k] = b; ack_ok[k] = 1; spur[k] = 0; bad_val[k] = 8'h00;
    end
  endtask

  task automatic load_tour();
    load(0, {CAL, 12'h000});
    load(1, mk_move(1'b0, NORTH, 4'd2));
    load(2, mk_move(1'b0, EAST, 4'd2));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    chk_en = 1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Three-command tour, all acked after 50 cycles.
    load_tour();
    plan_default(3, 50);
    run(3, -1, -1, 0);
    check("t1 sends", 16'(sent_q.size()), 16'd3);
    check("t1 cmd0", sent_at(0), 16'h2000);
    check("t1 cmd1", sent_at(1), 16'h4002);
    check("t1 cmd2", sent_at(2), 16'h4BF2);
    check("t1 first latency", 16'(send_cyc_at(0) - start_cyc), 16'd2);
    check("t1 spacing", 16'(send_cyc_at(1) - send_cyc_at(0)), 16'd52);
    check("t1 done", 16'(done), 16'd1);
    check("t1 busy", 16'(busy), 16'd0);
    check("t1 idx", 16'(cmd_idx), 16'd2);

    // Bad response on the second command.
    ack_ok[1] = 0; bad_val[1] = 8'h5A;
    run(3, -1, -1, 0);
    check("t2 sends", 16'(sent_q.size()), 16'd2);
    check("t2 err", 16'(err), 16'd1);
    check("t2 code", 16'(err_code), 16'd1);
    check("t2 idx", 16'(cmd_idx), 16'd1);

    // No response at all: timeout on the first command.
    plan_default(3, 50);
    b_del[0] = NEVER;
    run(3, -1, -1, 0);
    check("t3 err", 16'(err), 16'd1);
    check("t3 code", 16'(err_code), 16'd2);
    check("t3 idx", 16'(cmd_idx), 16'd0);
    check("t3 err delay", 16'(err_cyc - send_cyc_at(0)), 16'(TO + 1));

    // Empty program.
    run(0, -1, -1, 0);
    check("t4 done", 16'(done), 16'd1);
    check("t4 sends", 16'(sent_q.size()), 16'd0);

    // Write while busy is dropped; the next run still sends the original slot 0.
    plan_default(3, 20);
    run(3, 10, -1, 0);
    run(3, -1, -1, 0);
    check("t5 slot0", sent_at(0), 16'h2000);

    // Reset during WAIT_RESP of command 1, then restart from slot 0.
    plan_default(3, 50);
    b_del[1] = 40;
    run(3, -1, 64, 0);
    check("t6 cmd", cmd, 16'h0000);
    check("t6 done", 16'(done), 16'd0);
    load_tour();
    run(3, -1, -1, 0);
    check("t6 restart slot0", sent_at(0), 16'h2000);
    check("t6 restart done", 16'(done), 16'd1);

    // Response on the very expiry cycle is accepted.
    plan_default(3, 30);
    b_del[0] = TO;
    run(2, -1, -1, 0);
    check("t7 err", 16'(err), 16'd0);
    check("t7 done", 16'(done), 16'd1);
    check("t7 sends", 16'(sent_q.size()), 16'd2);

    // Randomized programs and responder behaviour.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < DEPTH; k++) load(k, 16'($urandom));
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, DEPTH));
      for (int k = 0; k < DEPTH; k++) begin
        a_del[k]  = $urandom_range(1, 6);
        ack_ok[k] = 1;
        spur[k]   = ($urandom_range(0, 3) == 0);
        bad_val[k] = 8'($urandom_range(0, 255));
        if (bad_val[k] == ACKB) bad_val[k] = 8'h00;
        m = $urandom_range(0, 99);
        if (m < 6) b_del[k] = NEVER;
        else if (m < 12) begin b_del[k] = a_del[k] + $urandom_range(0, 50); ack_ok[k] = 0; end
        else if (m < 15) b_del[k] = TO;
        else b_del[k] = a_del[k] + $urandom_range(0, 60);
      end
      run(n, ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 20)) : -1, -1, 1);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
